// File: rtl/upcnt_pkg.sv
// Shared types and helpers for the synchronous up counter (sync_up_counter).
package upcnt_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Loads above the terminal count saturate so no value above MAX is ever stored.
  function automatic logic [MAX_WIDTH-1:0] clamp_to_max(
    input logic [MAX_WIDTH-1:0] value,
    input logic [MAX_WIDTH-1:0] max
  );
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/upcnt_if.sv
// Control/status bundle of sync_up_counter; master drives controls, slave is the counter.
interface upcnt_if
  import upcnt_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             en;
  logic             start;
  logic             one_shot;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             busy;
  logic             done;

  modport master (
    output en, start, one_shot, load, load_val,
    input  count, tc, wrap, busy, done
  );

  modport slave (
    input  en, start, one_shot, load, load_val,
    output count, tc, wrap, busy, done
  );

endinterface

// File: rtl/upcnt_prescaler.sv
// Enable divisor for sync_up_counter: tick once every PRESCALE enabled cycles.
module upcnt_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sync_up_counter.sv
// Synchronous up counter 0..MAX with load, one-shot/free-run and wrap/tc/done flags.
// Optional enable prescaler is built when UPCNT_PRESCALE_EN is defined.
module sync_up_counter
  import upcnt_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MAX      = (1 << WIDTH) - 1,
  parameter int PRESCALE = 1
) (
  input logic   clk,
  input logic   rst,
  upcnt_if.slave bus
);

  localparam logic [1:0]       IDLE  = ST_IDLE;
  localparam logic [1:0]       RUN   = ST_RUN;
  localparam logic [1:0]       DONE  = ST_DONE;
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH || MAX < 1 || MAX > (1 << WIDTH) - 1 || PRESCALE < 1)
  begin : g_bad_params
    $error("sync_up_counter: illegal WIDTH/MAX/PRESCALE combination");
  end

  logic [1:0]       state_q;
  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic [WIDTH-1:0] load_clamped;
  logic             inc;

  assign load_clamped = WIDTH'(clamp_to_max(MAX_WIDTH'(bus.load_val), MAX_WIDTH'(MAX)));

`ifdef UPCNT_PRESCALE_EN
  logic tick;

  upcnt_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .clr  (bus.load | bus.start),
    .tick (tick)
  );

  // tick is already qualified by en inside the prescaler.
  assign inc = tick;
`else
  assign inc = bus.en;
`endif

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      state_q <= IDLE;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (bus.load) begin
        count_q <= load_clamped;
      end else if (bus.start && state_q != RUN) begin
        if (state_q == DONE) count_q <= '0;
        state_q <= RUN;
      end else if (state_q == RUN && inc) begin
        if (count_q == MAX_V) begin
          if (bus.one_shot) begin
            state_q <= DONE;
          end else begin
            count_q <= '0;
            wrap_q  <= 1'b1;
          end
        end else begin
          count_q <= count_q + WIDTH'(1);
        end
      end
    end
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.tc    = (count_q == MAX_V);
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);

endmodule
